axistream_pack: RTL and testbench
=================================

// Module: axistream_pack
// PURPOSE
//   Upstream companion to the unpacker: collects NUM_PACK narrow AXI-Stream words into one wide word.
//   An early src_tlast flushes a partial word with zero padding; dest_tcount reports the valid lanes.
//   A pack->unpack chain with equal DATA_WIDTH/NUM_PACK/BIG_ENDIAN returns the original word order.
// PARAMETERS
//   DATA_WIDTH  8     width of one narrow word (src_tdata)
//   NUM_PACK    4     narrow words per wide word; >=2
//   BIG_ENDIAN  1'b0  0: first received word -> lane 0 (LS); 1: first received word -> lane NUM_PACK-1 (MS)
// PORTS
//   clk          in   1                    clock; all logic on rising edge
//   rst          in   1                    synchronous reset, active-high
//   src_tvalid   in   1                    narrow input valid
//   src_tready   out  1                    narrow input ready
//   src_tdata    in   DATA_WIDTH           narrow input data
//   src_tlast    in   1                    last narrow word of packet
//   dest_tvalid  out  1                    wide output valid
//   dest_tready  in   1                    wide output ready
//   dest_tdata   out  DATA_WIDTH*NUM_PACK  packed data; unfilled lanes are 0
//   dest_tlast   out  1                    wide word closes a packet
//   dest_tcount  out  $clog2(NUM_PACK+1)   valid lanes in dest_tdata, 1..NUM_PACK
// BEHAVIOUR
//   One clock, clk. Reset is synchronous and active-high (rst).
//   - State: accumulator acc, lane counter cnt (0..NUM_PACK-1), output register (data/valid/last/count).
//   - Reset: dest_tvalid=0, dest_tlast=0, dest_tcount=0, dest_tdata=0, cnt=0, acc=0.
//     src_tready=0 while rst is high. Reset mid-packet discards the partial word.
//   - src_tready = !rst && (!dest_tvalid || dest_tready). It does not depend on src_tdata or src_tlast.
//   - Accept (src_tvalid && src_tready):
//       lane = BIG_ENDIAN ? NUM_PACK-1-cnt : cnt; the word is written to that lane.
//   - Complete = accept && (cnt==NUM_PACK-1 || src_tlast).
//       On complete: output data <= acc with the new lane merged; unwritten lanes are 0.
//       dest_tcount <= cnt+1; dest_tlast <= src_tlast; dest_tvalid <= 1.
//       acc <= 0 and cnt <= 0 on the same edge.
//       Otherwise on accept: cnt <= cnt+1 and acc is updated.
//   - Latency: the completing word is accepted at edge N; dest_tvalid is high after edge N.
//   - Output handshake:
//       dest_tvalid && dest_tready with no new complete -> dest_tvalid <= 0.
//       Transfer and complete on the same edge -> the new word replaces the old; dest_tvalid stays 1.
//   - Throughput: 1 narrow word per cycle is sustained while dest_tready=1; there are no bubbles.
//   - Backpressure: while dest_tvalid && !dest_tready, all dest_* outputs hold stable and src_tready=0.
//   - dest_tlast and dest_tcount are only meaningful when dest_tvalid=1.
//   - A tlast at cnt==NUM_PACK-1 gives a full word: tcount=NUM_PACK, tlast=1.
//   - The next packet always starts at lane "first" (cnt=0).
//   - cnt never exceeds NUM_PACK-1; all arithmetic is unsigned and wraps through the complete path only.
// TESTING (DATA_WIDTH=8, NUM_PACK=4, dest_tready=1 unless stated)
//   1. Send 11,22,33,44 (tlast on 44).
//      -> dest_tdata=0x44332211, tcount=4, tlast=1, valid 1 cycle after 44 is accepted.
//   2. BIG_ENDIAN=1, same stimulus.
//      -> dest_tdata=0x11223344, tcount=4, tlast=1.
//   3. Send AA, BB(tlast), then 01,02,03,04.
//      -> 0x0000BBAA with tcount=2, tlast=1; then 0x04030201 with tcount=4, tlast=0.
//   4. Hold dest_tready=0 while two wide words are sent.
//      -> src_tready drops once output is full, outputs stable; release gives both words in order, no loss.
//   5. rst pulse after 2 narrow words, then send 55,66,77,88.
//      -> during rst dest_tvalid=0 and src_tready=0; then 0x88776655 with tcount=4.
//   6. Stream 4 packets of 4 back-to-back, 1 word per cycle.
//      -> src_tready never drops, one wide word every 4 cycles.

Source files
------------

// File: rtl/axistream_pack.sv
// axistream_pack: gathers NUM_PACK narrow AXI-Stream words into one wide word.
// An early src_tlast flushes a zero-padded partial word; dest_tcount gives lanes.
module axistream_pack #(
   parameter int DATA_WIDTH = 8,
   parameter int NUM_PACK   = 4,
   parameter bit BIG_ENDIAN = 1'b0
) (
   input  logic                               clk,
   input  logic                               rst,
   input  logic                               src_tvalid,
   output logic                               src_tready,
   input  logic [DATA_WIDTH-1:0]              src_tdata,
   input  logic                               src_tlast,
   output logic                               dest_tvalid,
   input  logic                               dest_tready,
   output logic [DATA_WIDTH*NUM_PACK-1:0]     dest_tdata,
   output logic                               dest_tlast,
   output logic [$clog2(NUM_PACK+1)-1:0]      dest_tcount
);

   localparam int CW = $clog2(NUM_PACK);
   localparam int TW = $clog2(NUM_PACK + 1);
   localparam int WW = DATA_WIDTH * NUM_PACK;

   logic [CW-1:0] cnt;
   logic [CW-1:0] lane;
   logic [WW-1:0] acc;
   logic [WW-1:0] merged;
   logic          accept;
   logic          complete;

   // A new narrow word may enter whenever the output slot is free or draining.
   assign src_tready = !rst && (!dest_tvalid || dest_tready);
   assign accept     = src_tvalid && src_tready;
   assign complete   = accept && ((cnt == CW'(NUM_PACK - 1)) || src_tlast);
   assign lane       = BIG_ENDIAN ? (CW'(NUM_PACK - 1) - cnt) : cnt;

   // Accumulator with the incoming word dropped into its lane.
   always_comb begin
      merged = acc;
      for (int i = 0; i < NUM_PACK; i++) begin
         if (lane == CW'(i)) begin
            merged[i*DATA_WIDTH +: DATA_WIDTH] = src_tdata;
         end
      end
   end

   // Lane counter, accumulator and output register.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt         <= '0;
         acc         <= '0;
         dest_tvalid <= 1'b0;
         dest_tlast  <= 1'b0;
         dest_tcount <= '0;
         dest_tdata  <= '0;
      end else if (complete) begin
         dest_tdata  <= merged;
         dest_tcount <= TW'(cnt) + TW'(1);
         dest_tlast  <= src_tlast;
         dest_tvalid <= 1'b1;
         acc         <= '0;
         cnt         <= '0;
      end else begin
         if (accept) begin
            acc <= merged;
            cnt <= cnt + CW'(1);
         end
         if (dest_tvalid && dest_tready) begin
            dest_tvalid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_axistream_pack.sv
// tb_axistream_pack: scoreboard bench for both lane orders of axistream_pack.
// A packet-level model predicts wide words; a negedge monitor checks them.
module tb_axistream_pack;

   localparam int DW = 8;
   localparam int NP = 4;
   localparam int WW = DW * NP;
   localparam int TW = 3;

   typedef struct {
      logic [WW-1:0] le;
      logic [WW-1:0] be;
      logic [TW-1:0] cnt;
      logic          last;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          src_tvalid = 1'b0;
   logic [DW-1:0] src_tdata = '0;
   logic          src_tlast = 1'b0;
   logic          dest_tready = 1'b1;

   logic          src_tready;
   logic          dest_tvalid;
   logic [WW-1:0] dest_tdata;
   logic          dest_tlast;
   logic [TW-1:0] dest_tcount;

   logic          be_src_tready;
   logic          be_dest_tvalid;
   logic [WW-1:0] be_dest_tdata;
   logic          be_dest_tlast;
   logic [TW-1:0] be_dest_tcount;

   int errors = 0;
   int checks = 0;

   exp_t          sb[$];
   logic [DW-1:0] part[$];
   bit            occ = 1'b0;
   logic          exp_ready;

   always #5 clk = ~clk;

   axistream_pack #(.DATA_WIDTH(DW), .NUM_PACK(NP), .BIG_ENDIAN(1'b0)) u_le (
      .clk         (clk),
      .rst         (rst),
      .src_tvalid  (src_tvalid),
      .src_tready  (src_tready),
      .src_tdata   (src_tdata),
      .src_tlast   (src_tlast),
      .dest_tvalid (dest_tvalid),
      .dest_tready (dest_tready),
      .dest_tdata  (dest_tdata),
      .dest_tlast  (dest_tlast),
      .dest_tcount (dest_tcount)
   );

   axistream_pack #(.DATA_WIDTH(DW), .NUM_PACK(NP), .BIG_ENDIAN(1'b1)) u_be (
      .clk         (clk),
      .rst         (rst),
      .src_tvalid  (src_tvalid),
      .src_tready  (be_src_tready),
      .src_tdata   (src_tdata),
      .src_tlast   (src_tlast),
      .dest_tvalid (be_dest_tvalid),
      .dest_tready (dest_tready),
      .dest_tdata  (be_dest_tdata),
      .dest_tlast  (be_dest_tlast),
      .dest_tcount (be_dest_tcount)
   );

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
      end
   endtask

   // Model: the output slot holds at most one word; a packet fragment is
   // closed after NP words or on tlast.
   assign exp_ready = !rst && (!occ || dest_tready);

   always @(posedge clk) begin
      exp_t e;
      bit   rdy;
      rdy = !rst && (!occ || dest_tready);
      if (rst) begin
         occ = 1'b0;
         part.delete();
         sb.delete();
      end else begin
         if (occ && dest_tready) occ = 1'b0;
         if (src_tvalid && rdy) begin
            part.push_back(src_tdata);
            if (part.size() == NP || src_tlast) begin
               e.le = '0;
               e.be = '0;
               for (int k = 0; k < part.size(); k++) begin
                  e.le[k*DW +: DW]        = part[k];
                  e.be[(NP-1-k)*DW +: DW] = part[k];
               end
               e.cnt  = TW'(part.size());
               e.last = src_tlast;
               sb.push_back(e);
               occ = 1'b1;
               part.delete();
            end
         end
      end
   end

   // Monitor: handshake signals against the model, wide words against the
   // scoreboard front; a stalled word is rechecked each cycle.
   always @(negedge clk) begin
      exp_t f;
      chk("src_tready", {63'd0, src_tready}, {63'd0, exp_ready});
      chk("be_src_tready", {63'd0, be_src_tready}, {63'd0, exp_ready});
      chk("dest_tvalid", {63'd0, dest_tvalid}, {63'd0, occ});
      chk("be_dest_tvalid", {63'd0, be_dest_tvalid}, {63'd0, occ});
      if (dest_tvalid === 1'b1) begin
         if (sb.size() == 0) begin
            chk("sb_nonempty", 64'd0, 64'd1);
         end else begin
            f = sb[0];
            chk("le_data", {32'd0, dest_tdata}, {32'd0, f.le});
            chk("be_data", {32'd0, be_dest_tdata}, {32'd0, f.be});
            chk("le_count", {61'd0, dest_tcount}, {61'd0, f.cnt});
            chk("be_count", {61'd0, be_dest_tcount}, {61'd0, f.cnt});
            chk("le_last", {63'd0, dest_tlast}, {63'd0, f.last});
            chk("be_last", {63'd0, be_dest_tlast}, {63'd0, f.last});
            if (dest_tready) void'(sb.pop_front());
         end
      end
   end

   // Called at posedge+1; returns at posedge+1 after the word is taken.
   task automatic send(input logic [DW-1:0] d, input logic l);
      bit ok;
      bit r;
      ok = 1'b0;
      src_tvalid = 1'b1;
      src_tdata  = d;
      src_tlast  = l;
      for (int i = 0; i < 200 && !ok; i++) begin
         @(negedge clk);
         r = src_tready;
         @(posedge clk);
         #1;
         ok = r;
      end
      if (!ok) chk("send_timeout", 64'd0, 64'd1);
      src_tvalid = 1'b0;
      src_tlast  = 1'b0;
   endtask

   // Directed check of the next presented wide word against constants.
   task automatic wait_out(input string n, input logic [WW-1:0] le,
                           input logic [WW-1:0] be, input int c,
                           input logic l);
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20 && !seen; i++) begin
         @(negedge clk);
         seen = dest_tvalid;
      end
      chk({n, "_seen"}, {63'd0, seen}, 64'd1);
      chk({n, "_le"}, {32'd0, dest_tdata}, {32'd0, le});
      chk({n, "_be"}, {32'd0, be_dest_tdata}, {32'd0, be});
      chk({n, "_cnt"}, {61'd0, dest_tcount}, 64'(c));
      chk({n, "_last"}, {63'd0, dest_tlast}, {63'd0, l});
      @(posedge clk);
      #1;
   endtask

   initial begin
      time t0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_data", {32'd0, dest_tdata}, 64'd0);
      chk("rst_count", {61'd0, dest_tcount}, 64'd0);
      chk("rst_last", {63'd0, dest_tlast}, 64'd0);
      rst = 1'b0;

      // full packet, both lane orders
      send(8'h11, 1'b0);
      send(8'h22, 1'b0);
      send(8'h33, 1'b0);
      send(8'h44, 1'b1);
      wait_out("t1", 32'h44332211, 32'h11223344, 4, 1'b1);

      // short packet then full word without tlast
      send(8'hAA, 1'b0);
      send(8'hBB, 1'b1);
      wait_out("t3a", 32'h0000BBAA, 32'hAABB0000, 2, 1'b1);
      send(8'h01, 1'b0);
      send(8'h02, 1'b0);
      send(8'h03, 1'b0);
      send(8'h04, 1'b0);
      wait_out("t3b", 32'h04030201, 32'h01020304, 4, 1'b0);

      // backpressure across two wide words
      dest_tready = 1'b0;
      fork
         begin
            for (int i = 0; i < 8; i++) send(8'(8'h80 + i), (i % 4) == 3);
         end
         begin
            repeat (12) @(negedge clk);
            chk("bp_ready", {63'd0, src_tready}, 64'd0);
            chk("bp_valid", {63'd0, dest_tvalid}, 64'd1);
            @(posedge clk);
            #1;
            dest_tready = 1'b1;
         end
      join
      repeat (3) @(posedge clk);
      #1;

      // reset in mid-packet discards the fragment
      send(8'hE1, 1'b0);
      send(8'hE2, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      chk("rst_mid_ready", {63'd0, src_tready}, 64'd0);
      @(posedge clk);
      #1;
      @(negedge clk);
      chk("rst_mid_valid", {63'd0, dest_tvalid}, 64'd0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      send(8'h55, 1'b0);
      send(8'h66, 1'b0);
      send(8'h77, 1'b0);
      send(8'h88, 1'b0);
      wait_out("t5", 32'h88776655, 32'h55667788, 4, 1'b0);

      // back-to-back streaming, one word per cycle
      t0 = $time;
      for (int i = 0; i < 16; i++) send(8'(i * 3 + 7), (i % 4) == 3);
      chk("stream_time", 64'($time - t0), 64'd160);
      repeat (3) @(posedge clk);
      #1;

      // randomized traffic with random backpressure
      fork
         begin
            for (int i = 0; i < 300; i++) begin
               repeat ($urandom_range(0, 2)) @(posedge clk);
               #0;
               send(8'($urandom), $urandom_range(0, 4) == 0);
            end
         end
         begin
            for (int i = 0; i < 700; i++) begin
               @(posedge clk);
               #1;
               dest_tready = $urandom_range(0, 3) != 0;
            end
            dest_tready = 1'b1;
         end
      join
      dest_tready = 1'b1;
      send(8'h5A, 1'b1);
      repeat (5) @(posedge clk);
      #1;
      chk("drain_sb", 64'(sb.size()), 64'd0);
      chk("drain_part", 64'(part.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
